// File: rtl/counter_mod.sv
// counter_mod: up/down counter with terminal count MAX_VAL, wrap or saturate
// at the boundaries, synchronous clear and clamped load.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MAX_VAL  : terminal count (1..2**WIDTH-1)
//   PRESCALE : clock cycles per counting step (1..65536); only used when the
//              macro COUNTER_MOD_PRESCALE_EN is defined, ignored otherwise
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : counting enable
//   clr      : synchronous clear to 0
//   load     : synchronous load of min(load_val, MAX_VAL)
//   load_val : value to load
//   up_dn    : direction, 1 = up, 0 = down
//   sat_mode : boundary behaviour, 1 = saturate, 0 = wrap
//   cntr     : registered count
//   tc       : registered one-cycle pulse in the cycle cntr shows a wrapped value
//   at_lim   : combinational, cntr sits at the limit of the current direction
//
// Update priority per edge: rst > clr > load > count step.
module counter_mod #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cntr,
  output logic             tc,
  output logic             at_lim
);

  // Elaboration-time parameter range checks
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod: WIDTH must be in 2..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("counter_mod: MAX_VAL must be at least 1");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("counter_mod: PRESCALE must be in 1..65536");
  end

  logic             step;
  logic [WIDTH-1:0] cntr_d;
  logic [WIDTH-1:0] load_lim;
  logic             tc_d;
  logic             at_max;
  logic             at_zero;

`ifdef COUNTER_MOD_PRESCALE_EN
  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic          tick;

  // Tick on the last phase of each prescale period
  assign tick = (psc_q == PS_LAST);

  // Prescale phase advances only while enabled; clr/load restart the period
  always_comb begin
    psc_d = psc_q;
    if (clr || load) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = tick ? '0 : psc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  assign step = en && tick;
`else
  assign step = en;
`endif

  assign at_max   = (cntr == MAX_VAL);
  assign at_zero  = (cntr == '0);
  assign load_lim = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign at_lim   = up_dn ? at_max : at_zero;

  // Next count and wrap pulse; tc only fires on a wrapping step
  always_comb begin
    cntr_d = cntr;
    tc_d   = 1'b0;
    if (clr) begin
      cntr_d = '0;
    end else if (load) begin
      cntr_d = load_lim;
    end else if (step) begin
      if (up_dn) begin
        if (!at_max) begin
          cntr_d = cntr + WIDTH'(1);
        end else if (!sat_mode) begin
          cntr_d = '0;
          tc_d   = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          cntr_d = cntr - WIDTH'(1);
        end else if (!sat_mode) begin
          cntr_d = MAX_VAL;
          tc_d   = 1'b1;
        end
      end
    end
  end

  // Count and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cntr <= '0;
      tc   <= 1'b0;
    end else begin
      cntr <= cntr_d;
      tc   <= tc_d;
    end
  end

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 16, giving the counter width in bits (legal range 2..32).
REQ-002 The module SHALL provide parameter MAX_VAL, default 2**WIDTH-1, giving the terminal count (legal range 1..2**WIDTH-1).
REQ-003 The module SHALL provide parameter PRESCALE, default 1, giving the clock cycles per counting step (legal range 1..65536); it applies only under REQ-024.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port en, input, 1 bit: counting enable.
REQ-007 The module SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-008 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The module SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-010 The module SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-011 The module SHALL have port sat_mode, input, 1 bit: boundary mode, 1 = saturate, 0 = wrap.
REQ-012 The module SHALL have port cntr, output, WIDTH bits: the registered count value.
REQ-013 The module SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 The module SHALL have port at_lim, output, 1 bit: combinational flag, high when cntr == MAX_VAL with up_dn=1, or cntr == 0 with up_dn=0.

Function
REQ-015 Update priority per edge SHALL be rst > clr > load > count step; only the highest-priority active action takes effect.
REQ-016 Load SHALL write min(load_val, MAX_VAL) to cntr, independent of en; cntr shows the value on the next cycle (1-cycle latency).
REQ-017 A count step SHALL occur on an edge where en=1 and the step tick is high; without REQ-024, the tick is constantly 1.
REQ-018 Up step: cntr < MAX_VAL -> cntr+1; cntr == MAX_VAL -> 0 if sat_mode=0, held at MAX_VAL if sat_mode=1.
REQ-019 Down step: cntr > 0 -> cntr-1; cntr == 0 -> MAX_VAL if sat_mode=0, held at 0 if sat_mode=1.
REQ-020 tc SHALL be 1 for exactly the cycle in which cntr first shows a wrapped value (wrap mode only); in saturate mode, and after clr or load, tc SHALL be 0.
REQ-021 When en=0 and no clr or load is active, cntr SHALL hold and tc SHALL be 0.
REQ-022 Changing up_dn or sat_mode SHALL take effect on the next step, with no extra latency and no spurious tc.

Reset
REQ-023 While rst=1 at a clock edge, the module SHALL set cntr=0, tc=0, and the prescaler state to 0; at_lim SHALL then follow REQ-014, and reset asserted mid-count SHALL discard any in-progress step.

Configuration
REQ-024 When macro COUNTER_MOD_PRESCALE_EN is defined, the module SHALL contain an internal prescale counter (0..PRESCALE-1) that advances only while en=1 and produces the tick when it equals PRESCALE-1, then returns to 0.
REQ-025 With COUNTER_MOD_PRESCALE_EN, the prescale counter SHALL be cleared by rst, clr or load and SHALL hold while en=0; PRESCALE=1 SHALL behave identically to the macro-absent build.
REQ-026 Without COUNTER_MOD_PRESCALE_EN, the module SHALL contain no prescale logic, SHALL ignore PRESCALE, and SHALL step on every enabled cycle.

Verification (WIDTH=4, MAX_VAL=9, PRESCALE=3 where the macro is defined)
REQ-027 rst for 5 cycles, then en=1, up_dn=1, sat_mode=0 for 12 cycles -> cntr 0,1..9,0,1; tc high only in the cycle cntr shows 0 after 9.
REQ-028 cntr=0, up_dn=0, sat_mode=1, en=1 for 3 cycles -> cntr stays 0, at_lim=1, tc=0; switch to sat_mode=0 -> cntr=9 next cycle with tc=1.
REQ-029 load=1, load_val=14 -> cntr=9 next cycle; load and clr together with en=1 -> cntr=0.
REQ-030 Counting up to cntr=5, then rst=1 for one cycle -> cntr=0 and tc=0 next cycle; counting resumes from 0 once rst=0.
REQ-031 Macro defined, en=1 for 9 cycles from reset -> cntr steps 0->1->2->3, once every 3 cycles; en=0 for 2 cycles, then en=1 -> prescale phase preserved across the pause.
REQ-032 Macro absent -> each scenario above produces identical cntr values to a build with the macro defined and PRESCALE=1.
